// File: rtl/mat_pkg.sv
// mat_pkg: shared states, mode codes and sizing helpers for the systolic multiplier
package mat_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  localparam logic MODE_AB = 1'b0;
  localparam logic MODE_ABT = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int acc_w(input int w, input int frac, input int n);
    return 2 * w - frac + clog2(n) + 1;
  endfunction
endpackage

// File: rtl/mat_pe.sv
// mat_pe: one multiply-accumulate cell with registered a/b pass-through
module mat_pe import mat_pkg::*; #(
  parameter int W = 21,
  parameter int FRAC = 6,
  parameter int ACC_W = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [ACC_W-1:0] acc_o
);
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*W-1:0] prod;
  // full-width signed product floored by FRAC, accumulated while enabled
  always_comb begin
    prod = ($signed(a_i) * $signed(b_i)) >>> FRAC;
    a_d = clr ? '0 : en ? a_i : a_q;
    b_d = clr ? '0 : en ? b_i : b_q;
    acc_d = clr ? '0 : en ? acc_q + ACC_W'(prod) : acc_q;
  end
  // cell state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
  assign a_o = a_q;
  assign b_o = b_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/mat_systolic.sv
// mat_systolic: NxN fixed-point matrix multiply (A*B or A*B^T) on a skewed systolic grid
module mat_systolic import mat_pkg::*; #(
  parameter int N = 3,
  parameter int W = 21,
  parameter int FRAC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] m_flat,
  output logic             ovf
);
  localparam int ACC_W = acc_w(W, FRAC, N);
  localparam int L = 2 * N - 1;
  localparam int CW = clog2(3 * N) + 1;
  localparam logic [CW-1:0] LAST = CW'(3 * N - 2);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, done_q, done_d, ovf_q, ovf_d;
  logic [N*N*W-1:0] m_q, m_d, sat_flat;
  logic [N*N-1:0] sat_f;
  logic [W-1:0] a_sk_q [N][L];
  logic [W-1:0] a_sk_d [N][L];
  logic [W-1:0] b_sk_q [N][L];
  logic [W-1:0] b_sk_d [N][L];
  logic [W-1:0] ah [N][N+1];
  logic [W-1:0] bv [N+1][N];
  logic signed [ACC_W-1:0] acc [N][N];
  // row i of A / column i of B (row i when transposed) is preloaded i slots deep, then shifted out one per cycle
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar s = 0; s < L; s++) begin : g_slot
      logic [W-1:0] a_ld, b_ld, a_sh, b_sh;
      if (s >= i && s < i + N) begin : g_ld
        assign a_ld = a_flat[(i*N+s-i)*W +: W];
        assign b_ld = mode_q == MODE_ABT ? b_flat[(i*N+s-i)*W +: W] : b_flat[((s-i)*N+i)*W +: W];
      end else begin : g_zero
        assign a_ld = '0;
        assign b_ld = '0;
      end
      if (s < L - 1) begin : g_shift
        assign a_sh = a_sk_q[i][s+1];
        assign b_sh = b_sk_q[i][s+1];
      end else begin : g_tail
        assign a_sh = '0;
        assign b_sh = '0;
      end
      assign a_sk_d[i][s] = st_q == LOAD ? a_ld : st_q == COMPUTE ? a_sh : a_sk_q[i][s];
      assign b_sk_d[i][s] = st_q == LOAD ? b_ld : st_q == COMPUTE ? b_sh : b_sk_q[i][s];
    end
    assign ah[i][0] = a_sk_q[i][0];
    assign bv[0][i] = b_sk_q[i][0];
  end
  for (genvar i = 0; i < N; i++) begin : g_pe_r
    for (genvar j = 0; j < N; j++) begin : g_pe_c
      logic hi, lo;
      mat_pe #(.W(W), .FRAC(FRAC), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .rst(rst), .clr(st_q == LOAD), .en(st_q == COMPUTE),
        .a_i(ah[i][j]), .b_i(bv[i][j]), .a_o(ah[i][j+1]), .b_o(bv[i+1][j]), .acc_o(acc[i][j])
      );
      assign hi = acc[i][j] > MAXV;
      assign lo = acc[i][j] < MINV;
      assign sat_f[i*N+j] = hi | lo;
      assign sat_flat[(i*N+j)*W +: W] = hi ? MAXV[W-1:0] : lo ? MINV[W-1:0] : acc[i][j][W-1:0];
    end
  end
  // sequencing: load one cycle, stream 3N-1 cycles, saturate into the result register on drain
  always_comb begin
    st_d = st_q == IDLE ? (start ? LOAD : IDLE) : st_q == LOAD ? COMPUTE :
           st_q == COMPUTE ? (cnt_q == LAST ? DRAIN : COMPUTE) : IDLE;
    cnt_d = st_q == COMPUTE ? cnt_q + 1'b1 : '0;
    mode_d = st_q == IDLE && start ? mode : mode_q;
    done_d = st_q == DRAIN;
    m_d = st_q == DRAIN ? sat_flat : m_q;
    ovf_d = st_q == DRAIN ? |sat_f : ovf_q;
  end
  // control, skew and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      mode_q <= MODE_AB;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      m_q <= '0;
      a_sk_q <= '{default: '0};
      b_sk_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      m_q <= m_d;
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
    end
  end
  assign busy = st_q != IDLE;
  assign done = done_q;
  assign m_flat = m_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_mat_systolic.sv
// tb_mat_systolic: directed vector table plus hand sequences for the systolic multiplier
module tb_mat_systolic;
  localparam int N = 3, W = 21, FRAC = 6, MW = N * N * W;
  localparam int LAT = 3 * N + 2;
  typedef int arr9_t[9];
  typedef struct {
    logic mode;
    logic [MW-1:0] a, b, m;
    logic ovf;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [MW-1:0] a_flat = '0, b_flat = '0, m_flat;
  logic busy, done, ovf;
  int checks = 0, errors = 0;
  vec_t vt[8];
  arr9_t i64 = '{64, 0, 0, 0, 64, 0, 0, 0, 64};
  arr9_t i128 = '{128, 0, 0, 0, 128, 0, 0, 0, 128};
  arr9_t id = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  arr9_t s9 = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  arr9_t t9 = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
  arr9_t bx = '{-5, 3, 0, 7, -2, 9, 1, 1, -8};
  arr9_t mx = '{-10, 14, 2, 6, -4, 2, 0, 18, -16};

  always #5 clk = ~clk;

  mat_systolic #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy), .done(done), .m_flat(m_flat), .ovf(ovf)
  );

  function automatic logic [MW-1:0] pk(input arr9_t v);
    logic [MW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*W +: W] = W'(v[k]);
    return r;
  endfunction

  function automatic arr9_t fill(input int x);
    arr9_t r;
    for (int k = 0; k < 9; k++) r[k] = x;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // n = rising edges up to the one raising done, counting the start edge as the first
  task automatic run_op(input logic md, input logic [MW-1:0] a, input logic [MW-1:0] b, output int n);
    mode = md;
    a_flat = a;
    b_flat = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (n < 40 && !done) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n, dn;
    vt[0] = '{1'b0, pk(i64), pk(s9), pk(s9), 1'b0};
    vt[1] = '{1'b1, pk(i64), pk(s9), pk(t9), 1'b0};
    vt[2] = '{1'b0, pk(fill(-1)), pk(fill(1)), pk(fill(-3)), 1'b0};
    vt[3] = '{1'b0, pk(fill(1)), pk(fill(1)), pk(fill(0)), 1'b0};
    vt[4] = '{1'b0, pk(fill(524288)), pk(fill(524288)), pk(fill(1048575)), 1'b1};
    vt[5] = '{1'b0, pk(i64), pk(id), pk(id), 1'b0};
    vt[6] = '{1'b0, pk(fill(524288)), pk(fill(-524288)), pk(fill(-1048576)), 1'b1};
    vt[7] = '{1'b1, pk(i128), pk(bx), pk(mx), 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset m", m_flat, 0);
    chk("reset ovf", ovf, 0);
    for (int k = 0; k < 8; k++) begin
      run_op(vt[k].mode, vt[k].a, vt[k].b, n);
      chk($sformatf("v%0d latency", k), n, LAT);
      chk($sformatf("v%0d m", k), m_flat, vt[k].m);
      chk($sformatf("v%0d ovf", k), ovf, vt[k].ovf);
      chk($sformatf("v%0d busy at done", k), busy, 0);
      @(posedge clk);
      #1 chk($sformatf("v%0d done width", k), done, 0);
    end
    // result holds while a new operation is in flight
    mode = vt[0].mode;
    a_flat = vt[0].a;
    b_flat = vt[0].b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold busy", busy, 1);
    chk("hold m", m_flat, vt[7].m);
    chk("hold ovf", ovf, vt[7].ovf);
    n = 0;
    while (n < 40 && !done) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold final m", m_flat, vt[0].m);
    // back-to-back start in the done cycle
    run_op(vt[1].mode, vt[1].a, vt[1].b, n);
    chk("b2b latency", n, LAT);
    chk("b2b m", m_flat, vt[1].m);
    // second start while busy is ignored
    mode = vt[2].mode;
    a_flat = vt[2].a;
    b_flat = vt[2].b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0;
    for (int c = 2; c <= 30; c++) begin
      start = (c == 5);
      @(posedge clk);
      #1 start = 1'b0;
      if (done) dn++;
    end
    chk("ignored start dones", dn, 1);
    chk("ignored start m", m_flat, vt[2].m);
    // reset in the middle of a saturating run
    mode = vt[4].mode;
    a_flat = vt[4].a;
    b_flat = vt[4].b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst m", m_flat, 0);
    chk("mid rst ovf", ovf, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("mid rst no done", dn, 0);
    run_op(vt[5].mode, vt[5].a, vt[5].b, n);
    chk("post rst latency", n, LAT);
    chk("post rst m", m_flat, vt[5].m);
    chk("post rst ovf", ovf, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
